// File: rtl/exc_seq_ctrl.sv
// Exception / interrupt entry sequencer.
// Arbitrates synchronous exceptions against latched interrupt requests, then
// walks the CP0 write sequence (EPC, Cause, Status), jumps to the handler and
// handles the matching eret. Every strobe leaves the block from a flop.
module exc_seq_ctrl #(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               ie,
    input  logic               fetch_boundary,
    input  logic               exc_req,
    input  logic [1:0]         exc_code,
    input  logic               eret,
    output logic               busy,
    output logic               take,
    output logic [NUM_IRQ-1:0] ack,
    output logic               cp0_write,
    output logic [1:0]         cp0_dst,
    output logic [CAUSE_W-1:0] cause_code,
    output logic               pc_handler,
    output logic               pc_epc,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service,
    output logic               double_fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WEPC    = 3'd1,
        S_WCAUSE  = 3'd2,
        S_WSTATUS = 3'd3,
        S_JUMP    = 3'd4,
        S_RET     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [NUM_IRQ-1:0]   r_irq_d;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_ack;
    logic                 r_take;
    logic                 r_in_service;
    logic                 r_double_fault;
    logic                 r_cp0_write;
    logic [1:0]           r_cp0_dst;
    logic [CAUSE_W-1:0]   r_cause_lat;
    logic [CAUSE_W-1:0]   r_cause_code;
    logic                 r_pc_handler;
    logic                 r_pc_epc;

    logic [NUM_IRQ-1:0]   w_rise;
    logic [NUM_IRQ-1:0]   w_cand;
    logic [NUM_IRQ-1:0]   w_grant;
    logic [CAUSE_W-1:0]   w_irq_code;
    logic [CAUSE_W-1:0]   w_exc_code;
    logic                 w_idle;
    logic                 w_accept_exc;
    logic                 w_accept_irq;
    logic                 w_accept;
    logic                 w_double;
    logic                 w_eret_go;

    assign w_rise = irq & ~r_irq_d;
    assign w_cand = r_pending & irq_mask & {NUM_IRQ{ie & ~r_in_service}};
    assign w_idle = (r_state == S_IDLE);

    // Illegal exception code 0 is reported as "unimplemented" (2).
    assign w_exc_code = (exc_code == 2'd0) ? CAUSE_W'(2) : CAUSE_W'(exc_code);

    // Exceptions are taken in any IDLE cycle and shadow a same-cycle interrupt;
    // interrupts wait for a fetch boundary. An exception while still in service
    // is never taken, only flagged.
    assign w_accept_exc = w_idle & exc_req & ~r_in_service;
    assign w_accept_irq = w_idle & ~exc_req & (|w_cand) & fetch_boundary;
    assign w_accept     = w_accept_exc | w_accept_irq;
    assign w_double     = w_idle & exc_req & r_in_service;
    assign w_eret_go    = w_idle & eret & r_in_service;

    // Lowest-index candidate wins: scanning downward leaves the lowest hit last.
    always_comb begin
        w_grant    = '0;
        w_irq_code = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
                w_irq_code = CAUSE_W'(4 + i);
            end
        end
    end

    // Next-state logic; every non-IDLE state lasts exactly one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)       w_next = S_WEPC;
                else if (w_eret_go) w_next = S_RET;
            end
            S_WEPC:    w_next = S_WCAUSE;
            S_WCAUSE:  w_next = S_WSTATUS;
            S_WSTATUS: w_next = S_JUMP;
            S_JUMP:    w_next = S_IDLE;
            S_RET:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Edge history and pending latch; a new edge overrides a same-cycle ack clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_d   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_d   <= irq;
            r_pending <= (r_pending & ~r_ack) | w_rise;
        end
    end

    // Acceptance bookkeeping: take/ack pulses, captured cause, service flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_take         <= 1'b0;
            r_ack          <= '0;
            r_cause_lat    <= '0;
            r_in_service   <= 1'b0;
            r_double_fault <= 1'b0;
        end else begin
            r_take <= w_accept;
            r_ack  <= w_accept_irq ? w_grant : '0;
            if (w_accept_exc)      r_cause_lat <= w_exc_code;
            else if (w_accept_irq) r_cause_lat <= w_irq_code;
            if (w_accept)               r_in_service <= 1'b1;
            else if (r_state == S_RET)  r_in_service <= 1'b0;
            if (w_double) r_double_fault <= 1'b1;
        end
    end

    // Registered per-state strobes, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cp0_write  <= 1'b0;
            r_cp0_dst    <= 2'd0;
            r_cause_code <= '0;
            r_pc_handler <= 1'b0;
            r_pc_epc     <= 1'b0;
        end else begin
            r_cp0_write  <= (w_next == S_WEPC) || (w_next == S_WCAUSE) ||
                            (w_next == S_WSTATUS);
            r_cp0_dst    <= (w_next == S_WCAUSE)  ? 2'd1 :
                            (w_next == S_WSTATUS) ? 2'd2 : 2'd0;
            r_cause_code <= (w_next == S_WCAUSE) ? r_cause_lat : '0;
            r_pc_handler <= (w_next == S_JUMP);
            r_pc_epc     <= (w_next == S_RET);
        end
    end

    assign busy         = ~w_idle;
    assign take         = r_take;
    assign ack          = r_ack;
    assign cp0_write    = r_cp0_write;
    assign cp0_dst      = r_cp0_dst;
    assign cause_code   = r_cause_code;
    assign pc_handler   = r_pc_handler;
    assign pc_epc       = r_pc_epc;
    assign pending      = r_pending;
    assign in_service   = r_in_service;
    assign double_fault = r_double_fault;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed bench for exc_seq_ctrl: a 4-channel instance (A) and a
// 16-channel instance (B) sharing clock and reset.
module tb_exc_seq_ctrl;

    logic clk;
    logic reset;

    // Instance A: NUM_IRQ=4
    logic [3:0]  irq_a, mask_a, ack_a, pend_a;
    logic        ie_a, fb_a, exc_req_a, eret_a;
    logic [1:0]  code_a, dst_a;
    logic [4:0]  cause_a;
    logic        busy_a, take_a, cp0w_a, pch_a, pce_a, insvc_a, df_a;

    // Instance B: NUM_IRQ=16
    logic [15:0] irq_b, mask_b, ack_b, pend_b;
    logic        ie_b, fb_b, exc_req_b, eret_b;
    logic [1:0]  code_b, dst_b;
    logic [4:0]  cause_b;
    logic        busy_b, take_b, cp0w_b, pch_b, pce_b, insvc_b, df_b;

    int n_checks = 0;
    int n_errors = 0;

    exc_seq_ctrl #(.NUM_IRQ(4), .CAUSE_W(5)) u_dut_a (
        .clk(clk), .reset(reset), .irq(irq_a), .irq_mask(mask_a), .ie(ie_a),
        .fetch_boundary(fb_a), .exc_req(exc_req_a), .exc_code(code_a), .eret(eret_a),
        .busy(busy_a), .take(take_a), .ack(ack_a), .cp0_write(cp0w_a), .cp0_dst(dst_a),
        .cause_code(cause_a), .pc_handler(pch_a), .pc_epc(pce_a), .pending(pend_a),
        .in_service(insvc_a), .double_fault(df_a)
    );

    exc_seq_ctrl #(.NUM_IRQ(16), .CAUSE_W(5)) u_dut_b (
        .clk(clk), .reset(reset), .irq(irq_b), .irq_mask(mask_b), .ie(ie_b),
        .fetch_boundary(fb_b), .exc_req(exc_req_b), .exc_code(code_b), .eret(eret_b),
        .busy(busy_b), .take(take_b), .ack(ack_b), .cp0_write(cp0w_b), .cp0_dst(dst_b),
        .cause_code(cause_b), .pc_handler(pch_b), .pc_epc(pce_b), .pending(pend_b),
        .in_service(insvc_b), .double_fault(df_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        irq_a = '0; mask_a = 4'hF; ie_a = 1'b1; fb_a = 1'b1;
        exc_req_a = 1'b0; code_a = 2'd0; eret_a = 1'b0;
        irq_b = 16'h8000; mask_b = 16'hFFFF; ie_b = 1'b1; fb_b = 1'b1;
        exc_req_b = 1'b0; code_b = 2'd0; eret_b = 1'b0;
        #1 reset = 1'b0;
        #2;
        // Reset state
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_take",  32'(take_a),  32'd0);
        check("rst_pend",  32'(pend_a),  32'd0);
        check("rst_insvc", 32'(insvc_a), 32'd0);
        check("rst_df",    32'(df_a),    32'd0);
        step(2);
        check("rst_pend_b_held", 32'(pend_b), 32'd0);
        reset = 1'b1;

        // B: irq[15] high through reset counts as an edge on the first clock
        step(1);
        check("b_pend15", 32'(pend_b), 32'h8000);
        check("b_take_early", 32'(take_b), 32'd0);
        step(1);
        check("b_take", 32'(take_b), 32'd1);
        check("b_ack15", 32'(ack_b), 32'h8000);
        step(1);
        check("b_cause19", 32'(cause_b), 32'd19);
        check("b_dst_cause", 32'(dst_b), 32'd1);
        check("b_pend_clr", 32'(pend_b), 32'd0);
        irq_b = 16'h0000;
        step(3);
        check("b_idle", 32'(busy_b), 32'd0);
        eret_b = 1'b1;
        step(1);
        eret_b = 1'b0;
        step(1);
        check("b_insvc_clr", 32'(insvc_b), 32'd0);
        irq_b = 16'h0008;
        step(1);
        irq_b = 16'h0000;
        step(1);
        check("b_ack3", 32'(ack_b), 32'h0008);
        irq_b = 16'h0008;            // new edge during the ack cycle
        step(1);
        check("b_pend3_setwins", 32'(pend_b), 32'h0008);
        irq_b = 16'h0000;

        // A: two pending, lowest enabled channel (1) wins
        irq_a = 4'b0110;
        step(1);
        check("a_pend_6", 32'(pend_a), 32'h6);
        step(1);
        check("a_take", 32'(take_a), 32'd1);
        check("a_ack_0010", 32'(ack_a), 32'h2);
        check("a_busy_wepc", 32'(busy_a), 32'd1);
        check("a_cp0w_wepc", 32'(cp0w_a), 32'd1);
        check("a_dst_epc", 32'(dst_a), 32'd0);
        check("a_insvc_set", 32'(insvc_a), 32'd1);
        exc_req_a = 1'b1; code_a = 2'd3;    // busy: must be dropped
        step(1);
        exc_req_a = 1'b0;
        check("a_cause5", 32'(cause_a), 32'd5);
        check("a_dst_cause", 32'(dst_a), 32'd1);
        check("a_pend2_stays", 32'(pend_a), 32'h4);
        check("a_take_pulse", 32'(take_a), 32'd0);
        check("a_ack_pulse", 32'(ack_a), 32'd0);
        step(1);
        check("a_dst_status", 32'(dst_a), 32'd2);
        check("a_cause_zero", 32'(cause_a), 32'd0);
        step(1);
        check("a_pch", 32'(pch_a), 32'd1);
        check("a_cp0w_jump", 32'(cp0w_a), 32'd0);
        fb_a = 1'b0;
        step(1);
        check("a_idle_busy", 32'(busy_a), 32'd0);
        check("a_idle_insvc", 32'(insvc_a), 32'd1);
        check("a_busy_exc_no_df", 32'(df_a), 32'd0);
        eret_a = 1'b1;
        step(1);
        eret_a = 1'b0;
        check("a_ret_pce", 32'(pce_a), 32'd1);
        check("a_ret_busy", 32'(busy_a), 32'd1);
        step(1);
        check("a_ret_done_busy", 32'(busy_a), 32'd0);
        check("a_ret_done_insvc", 32'(insvc_a), 32'd0);
        check("a_ret_done_pce", 32'(pce_a), 32'd0);
        step(1);
        check("a_no_fb_no_take", 32'(take_a), 32'd0);
        check("a_pend_kept", 32'(pend_a), 32'h4);
        eret_a = 1'b1;                       // not in service: ignored
        step(1);
        eret_a = 1'b0;
        check("a_eret_ignored", 32'(busy_a), 32'd0);

        // A: syscall and new irq[0] edge in the same cycle
        irq_a = 4'b0111;
        exc_req_a = 1'b1; code_a = 2'd1;
        step(1);
        exc_req_a = 1'b0;
        check("a_sys_take", 32'(take_a), 32'd1);
        check("a_sys_noack", 32'(ack_a), 32'd0);
        check("a_sys_pend", 32'(pend_a), 32'h5);
        step(1);
        check("a_sys_cause1", 32'(cause_a), 32'd1);
        fb_a = 1'b1;
        step(4);
        check("a_insvc_blocks_irq", 32'(take_a), 32'd0);
        eret_a = 1'b1;
        step(1);
        eret_a = 1'b0;
        step(1);
        check("a_after_ret_take", 32'(take_a), 32'd0);
        step(1);
        check("a_irq0_take", 32'(take_a), 32'd1);
        check("a_irq0_ack", 32'(ack_a), 32'h1);
        step(1);
        check("a_irq0_cause4", 32'(cause_a), 32'd4);
        check("a_irq0_pend", 32'(pend_a), 32'h4);
        step(3);

        // A: exception while in service and idle
        exc_req_a = 1'b1; code_a = 2'd3;
        step(1);
        exc_req_a = 1'b0;
        check("a_df_notake", 32'(take_a), 32'd0);
        check("a_df_set", 32'(df_a), 32'd1);
        check("a_df_busy", 32'(busy_a), 32'd0);
        step(1);
        check("a_df_sticky", 32'(df_a), 32'd1);
        eret_a = 1'b1;
        step(1);
        eret_a = 1'b0;
        step(1);
        exc_req_a = 1'b1; code_a = 2'd0;     // illegal code beats pending irq[2]
        step(1);
        exc_req_a = 1'b0;
        check("a_c0_take", 32'(take_a), 32'd1);
        check("a_c0_noack", 32'(ack_a), 32'd0);
        step(1);
        check("a_c0_cause2", 32'(cause_a), 32'd2);
        check("a_df_still", 32'(df_a), 32'd1);

        // Reset mid-WCAUSE
        reset = 1'b0;
        #1;
        check("ar_cp0w", 32'(cp0w_a), 32'd0);
        check("ar_cause", 32'(cause_a), 32'd0);
        check("ar_busy", 32'(busy_a), 32'd0);
        check("ar_pend", 32'(pend_a), 32'd0);
        check("ar_df", 32'(df_a), 32'd0);
        check("ar_insvc", 32'(insvc_a), 32'd0);
        fb_a = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        check("ar_edge_after_rel", 32'(pend_a), 32'h7);
        check("ar_idle", 32'(busy_a), 32'd0);
        check("ar_notake", 32'(take_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
